// File: rtl/spi_rx_axis.sv
// Oversampling SPI mode-0 frame receiver emitting each frame as one AXI4-Stream word.
// Optional feature macro SPI_RX_TUSER_EN adds m_axis_tuser = {cs index, bit count capped at 32}.
module spi_rx_axis #(
    parameter int WIDTH    = 32,
    parameter int CS_WIDTH = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                sclk,
    input  logic [CS_WIDTH-1:0] cs,
    input  logic                sdi,
    output logic [WIDTH-1:0]    m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
`ifdef SPI_RX_TUSER_EN
    output logic [7:0]          m_axis_tuser,
`endif
    output logic                overrun,
    output logic [15:0]         drop_count
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EMIT, S_ABORT} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_sclk_s1, r_sclk_s2, r_sclk_h;
    logic [CS_WIDTH-1:0] r_cs_s1, r_cs_s2;
    logic                r_sdi_s1, r_sdi_s2;
    logic [1:0]          r_primed;
    logic                r_armed;
    logic [CS_WIDTH-1:0] r_cs_mask;
    logic [WIDTH-1:0]    r_shreg;
    logic [5:0]          r_cnt;
    logic                w_sclk_rise, w_all_high, w_one_low;
    logic                w_latch, w_shift, w_emit, w_abort, w_load, w_drop;

    function automatic logic one_low(input logic [CS_WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < CS_WIDTH; i++)
            if (!v[i]) n++;
        return (n == 1);
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_h  <= 1'b0;
            r_cs_s1   <= '1;
            r_cs_s2   <= '1;
            r_sdi_s1  <= 1'b0;
            r_sdi_s2  <= 1'b0;
            r_primed  <= 2'b00;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_h  <= r_sclk_s2;
            r_cs_s1   <= cs;
            r_cs_s2   <= r_cs_s1;
            r_sdi_s1  <= sdi;
            r_sdi_s2  <= r_sdi_s1;
            r_primed  <= {r_primed[0], 1'b1};
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h;
    assign w_all_high  = &r_cs_s2;
    assign w_one_low   = one_low(r_cs_s2);

    // Arming waits until the synchronizers hold real pin values, so a frame
    // already running across reset or an abort is never picked up midway.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_armed <= 1'b0;
        else if (r_state == S_ABORT)
            r_armed <= 1'b0;
        else if (r_primed[1] && w_all_high)
            r_armed <= 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_shift = 1'b0;
        w_emit  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && w_one_low) begin
                    w_latch = 1'b1;
                    w_next  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_all_high)
                    w_next = S_EMIT;
                else if (r_cs_s2 != r_cs_mask)
                    w_next = S_ABORT;
                else if (w_sclk_rise)
                    w_shift = 1'b1;
            end
            S_EMIT: begin
                w_emit = 1'b1;
                w_next = S_IDLE;
            end
            S_ABORT: begin
                w_abort = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (w_latch) begin
            r_cs_mask <= r_cs_s2;
            r_shreg   <= '0;
            r_cnt     <= 6'd0;
        end else if (w_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], r_sdi_s2};
            if (r_cnt != 6'd63) r_cnt <= r_cnt + 6'd1;
        end
    end

    // An accept in the same cycle frees the slot, so the new word loads instead of dropping.
    assign w_load = w_emit && (r_cnt != 6'd0) && (!m_axis_tvalid || m_axis_tready);
    assign w_drop = w_emit && (r_cnt != 6'd0) && m_axis_tvalid && !m_axis_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
            drop_count    <= 16'd0;
        end else begin
            if (w_load) begin
                m_axis_tdata  <= r_shreg;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            overrun <= w_drop | w_abort;
            if ((w_drop || w_abort) && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

`ifdef SPI_RX_TUSER_EN
    function automatic logic [1:0] low_index(input logic [CS_WIDTH-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < CS_WIDTH; i++)
            if (!v[i]) idx = i[1:0];
        return idx;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            m_axis_tuser <= 8'd0;
        else if (w_load)
            m_axis_tuser <= {low_index(r_cs_mask), (r_cnt > 6'd32) ? 6'd32 : r_cnt};
    end
`endif

endmodule

// File: tb/tb_spi_rx_axis.sv
// Scoreboard bench for spi_rx_axis: SPI master stimulus, frame-level reference model, decoupled monitor.
module tb_spi_rx_axis;
    localparam int WIDTH    = 32;
    localparam int CS_WIDTH = 4;

    logic                aclk    = 1'b0;
    logic                aresetn = 1'b0;
    logic                sclk    = 1'b0;
    logic                sdi     = 1'b0;
    logic                tready  = 1'b0;
    logic [CS_WIDTH-1:0] cs      = '1;
    logic [WIDTH-1:0]    tdata;
    logic                tvalid;
    logic                overrun;
    logic [15:0]         drop_count;
`ifdef SPI_RX_TUSER_EN
    logic [7:0]          tuser;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  user;
    } beat_t;

    beat_t exp_q[$];
    int n_vec    = 0;
    int n_fail   = 0;
    int ovr_seen = 0;
    int exp_ovr  = 0;
    int exp_drop = 0;

    always #5 aclk = ~aclk;

    spi_rx_axis #(.WIDTH(WIDTH), .CS_WIDTH(CS_WIDTH)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .sclk          (sclk),
        .cs            (cs),
        .sdi           (sdi),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
`ifdef SPI_RX_TUSER_EN
        .m_axis_tuser  (tuser),
`endif
        .overrun       (overrun),
        .drop_count    (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Handshake seen at the falling edge completes on the following rising edge.
    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && overrun) ovr_seen++;
            if (aresetn && tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", tdata, e.data);
`ifdef SPI_RX_TUSER_EN
                    check("tuser", {24'd0, tuser}, {24'd0, e.user});
`endif
                end
            end
        end
    endtask

    // Frame-level model: the output slot is full exactly when a word is still owed to the monitor.
    task automatic model_frame(input int idx, input logic [63:0] d, input int nbits);
        beat_t      b;
        logic [63:0] m;
        logic [1:0] i2;
        int         c;
        if (nbits == 0) return;
        if (exp_q.size() != 0) begin
            exp_drop++;
            exp_ovr++;
            return;
        end
        m      = (nbits >= 32) ? 64'hFFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        m      = d & m;
        i2     = idx[1:0];
        c      = (nbits > 32) ? 32 : nbits;
        b.data = m[31:0];
        b.user = {i2, c[5:0]};
        exp_q.push_back(b);
    endtask

    task automatic shift_bits(input logic [63:0] d, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = d[i];
            cyc(5);
            sclk = 1'b1;
            cyc(5);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int idx, input logic [63:0] d, input int nbits, input bit lat);
        cs = '1;
        cs[idx] = 1'b0;
        cyc(4);
        shift_bits(d, nbits);
        cyc(4);
        model_frame(idx, d, nbits);
        cs = '1;
        if (lat) begin
            cyc(3);
            check("latency_before", {31'd0, tvalid}, 32'd0);
            cyc(1);
            check("latency_at", {31'd0, tvalid}, 32'd1);
            cyc(6);
        end else begin
            cyc(10);
        end
    endtask

    initial begin
        logic [63:0] d;
        int          idx, nb;

        fork
            monitor();
        join_none

        // reset state
        cyc(3);
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_drop", {16'd0, drop_count}, 32'd0);
        aresetn = 1'b1;
        cyc(5);

        tready = 1'b1;
        frame(1, 64'hC001E801, 32, 1'b1);
        check("drop_after_first", {16'd0, drop_count}, 32'd0);

        frame(0, 64'hABCDEF, 24, 1'b0);
        frame(0, 64'h12_3456789A, 40, 1'b0);

        // backpressure: second frame must be dropped, held word untouched
        tready = 1'b0;
        frame(2, 64'h11111111, 32, 1'b0);
        frame(2, 64'h22222222, 32, 1'b0);
        check("hold_tvalid", {31'd0, tvalid}, 32'd1);
        check("hold_tdata", tdata, 32'h11111111);
        check("ovr_drop", {16'd0, drop_count}, exp_drop);
        check("ovr_pulses", ovr_seen, exp_ovr);
        tready = 1'b1;
        cyc(5);
        check("hold_drained", exp_q.size(), 32'd0);
        check("hold_tvalid_low", {31'd0, tvalid}, 32'd0);

        // cs low with no clocks is a silent empty frame
        cs = 4'b1011;
        cyc(20);
        cs = '1;
        cyc(10);
        check("empty_drop", {16'd0, drop_count}, exp_drop);
        check("empty_ovr", ovr_seen, exp_ovr);

        // second chip select joins mid-frame
        cs = 4'b1110;
        cyc(4);
        shift_bits(64'h5A, 8);
        cyc(3);
        cs = 4'b0110;
        cyc(10);
        exp_drop++;
        exp_ovr++;
        cs = '1;
        cyc(10);
        check("abort_drop", {16'd0, drop_count}, exp_drop);
        check("abort_ovr", ovr_seen, exp_ovr);
        frame(3, 64'hA5, 8, 1'b0);

        for (int k = 0; k < 12; k++) begin
            idx = $urandom_range(0, CS_WIDTH - 1);
            nb  = $urandom_range(1, 40);
            d   = {$urandom, $urandom};
            frame(idx, d, nb, 1'b0);
        end
        check("rand_drop", {16'd0, drop_count}, exp_drop);

        // reset in the middle of a frame
        cs = 4'b1101;
        cyc(4);
        shift_bits(64'hFFF, 12);
        aresetn = 1'b0;
        cyc(2);
        check("midrst_tvalid", {31'd0, tvalid}, 32'd0);
        check("midrst_tdata", tdata, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        check("midrst_drop", {16'd0, drop_count}, 32'd0);
        aresetn  = 1'b1;
        exp_drop = 0;
        shift_bits(64'hABCDE, 20);
        cyc(4);
        cs = '1;
        cyc(10);
        check("midrst_no_beat", exp_q.size(), 32'd0);
        check("midrst_drop_after", {16'd0, drop_count}, 32'd0);
        frame(0, 64'hDEADBEEF, 32, 1'b0);

        cyc(20);
        check("final_pending", exp_q.size(), 32'd0);
        check("final_ovr", ovr_seen, exp_ovr);
        check("final_drop", {16'd0, drop_count}, exp_drop);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
